i2c_apb_regs: RTL and testbench
===============================

Name: i2c_apb_regs

Overview:
APB slave register bank for the I2C master, sitting directly downstream of the APB bridge. It decodes each APB access phase and returns apb_ready with a configurable number of wait states. It holds the prescale, control, transmit and command registers that drive the I2C byte controller. It also captures the byte controller's status and receive data and raises the interrupt.

Parameters:
BASE_ADDR, 32'h0000_0000, block base; apb_addr[31:8] must equal BASE_ADDR[31:8] for a hit
WAIT_STATES, 0, extra access-phase cycles before apb_ready (0..15)
PRESCALE_RST, 16'hFFFF, reset value of PRESCALE

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
apb_sel  in  1  APB select
apb_en  in  1  APB enable (access phase)
apb_write  in  1  1=write, 0=read
apb_addr  in  32  byte address
apb_wdata  in  32  write data
apb_ready  out  1  access complete
apb_rdata  out  32  read data, valid while apb_ready=1
core_en  out  1  CTRL[0]
prescale  out  16  PRESCALE[15:0]
txd  out  8  TXDATA[7:0]
cmd_sta, cmd_sto, cmd_rd, cmd_wr  out  1 each  pending command bits (held)
cmd_ack_n  out  1  ACK value to send on read
rxd  in  8  received byte from byte controller
cmd_done  in  1  one-cycle pulse: command finished
rx_ack  in  1  ACK received from slave (1 = NACK)
busy  in  1  bus busy
arb_lost  in  1  one-cycle pulse: arbitration lost
irq  out  1  interrupt, irq_flag & CTRL[1]

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and registers 0, except PRESCALE=PRESCALE_RST. Wait counter 0.
- Register map, offset = apb_addr[7:0]:
  - 0x00 PRESCALE: RW, [15:0].
  - 0x04 CTRL: RW, [0] core_en, [1] irq_en.
  - 0x08 TXDATA: RW, [7:0].
  - 0x0C CMD: W; read returns {ack_n, wr, rd, sto, sta} in [4:0]. Bits: [0] STA, [1] STO, [2] RD, [3] WR, [4] ACK_N, [7] IACK.
  - 0x10 RXDATA: RO, [7:0].
  - 0x14 STATUS: RO. [0] busy, [1] tip=cmd_rd|cmd_wr, [2] rx_ack (latched), [3] al (latched), [4] irq_flag.
- Unmapped offset or base mismatch: read returns 0, write is ignored, apb_ready still asserted. A miss never hangs the bus.
- Unused register bits read 0.
- Wait-state handshake:
  - Counter increments each cycle apb_sel&apb_en&!apb_ready.
  - apb_ready = apb_sel&apb_en&(cnt==WAIT_STATES), combinational from cnt.
  - Counter clears when apb_en=0 or on the completing cycle.
  - WAIT_STATES=0 gives apb_ready in the first access cycle.
- apb_rdata is combinational from the registers and is 0 when apb_ready=0.
- Writes commit on the clock edge where apb_sel&apb_en&apb_write&apb_ready. Exactly one commit per access.
- CMD register:
  - Write with core_en=0: STA/STO/RD/WR/ACK_N are ignored; IACK still acts.
  - Written bits set and hold cmd_* until a cmd_done or arb_lost pulse clears STA/STO/RD/WR (ACK_N persists).
  - CMD write on the same edge as cmd_done: the write wins, and the new bits are loaded.
- RXDATA and rx_ack load on cmd_done. al sets on arb_lost and clears on a CMD write with STA=1.
- irq_flag:
  - Sets on cmd_done|arb_lost.
  - Clears on a CMD write with IACK=1.
  - Simultaneous set and clear: set wins.
- Reset mid-access: apb_ready drops immediately (asynchronous) and no write commits.

Decomposition:
- Package i2c_regs_pkg: register offsets, CMD/STATUS/CTRL bit indices, PRESCALE_RST default, register address width (8).
- One natural sub-module: apb_wait_timer (counter plus apb_ready generation, parameter WAIT_STATES). The register bank and IRQ logic stay in i2c_apb_regs.

Test Plan:
- Release reset with WAIT_STATES=0, read each offset 0x00..0x14 -> 0xFFFF, 0, 0, 0, 0, 0. apb_ready asserted in the first access cycle.
- WAIT_STATES=2: write 0x00=0x0063, then read it back -> apb_ready high on the 3rd apb_en cycle of each access; prescale=0x0063 after the write edge; readback 0x63.
- CTRL=0x3, TXDATA=0xA5, CMD=0x09 -> cmd_sta=cmd_wr=1, STATUS.tip=1. Then pulse cmd_done -> cmd bits clear, irq_flag=1, irq=1.
- Pulse cmd_done with rxd=0x3C, rx_ack=1 on the same edge as a CMD write of 0x80 -> RXDATA=0x3C, STATUS.rx_ack=1, irq_flag stays 1 (set wins). A following IACK write -> irq=0.
- With core_en=0, write CMD=0x04 -> cmd_rd stays 0. Access offset 0x40 and apb_addr[31:8]≠BASE -> apb_ready asserted, rdata=0, no register changes.
- Assert rst_n low during a write access with WAIT_STATES=3 -> apb_ready=0 immediately, register unchanged after reset release.

Source files
------------

// File: rtl/i2c_apb_regs_pkg.sv
// Shared constants for the I2C master APB register bank: register offsets,
// bit positions inside CMD/STATUS/CTRL and reset defaults.
package i2c_regs_pkg;

    localparam int          REG_AW           = 8;
    localparam logic [15:0] PRESCALE_RST_DEF = 16'hFFFF;

    localparam logic [REG_AW-1:0] OFF_PRESCALE = 8'h00;
    localparam logic [REG_AW-1:0] OFF_CTRL     = 8'h04;
    localparam logic [REG_AW-1:0] OFF_TXDATA   = 8'h08;
    localparam logic [REG_AW-1:0] OFF_CMD      = 8'h0C;
    localparam logic [REG_AW-1:0] OFF_RXDATA   = 8'h10;
    localparam logic [REG_AW-1:0] OFF_STATUS   = 8'h14;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IEN = 1;

    localparam int CMD_STA   = 0;
    localparam int CMD_STO   = 1;
    localparam int CMD_RD    = 2;
    localparam int CMD_WR    = 3;
    localparam int CMD_ACKN  = 4;
    localparam int CMD_IACK  = 7;

    localparam int STAT_BUSY = 0;
    localparam int STAT_TIP  = 1;
    localparam int STAT_RXAK = 2;
    localparam int STAT_AL   = 3;
    localparam int STAT_IRQ  = 4;

endpackage

// File: rtl/i2c_apb_regs_if.sv
// APB bus bundle between the bridge (master) and the I2C register bank (slave).
interface i2c_apb_regs_if;
    logic        apb_sel;
    logic        apb_en;
    logic        apb_write;
    logic [31:0] apb_addr;
    logic [31:0] apb_wdata;
    logic        apb_ready;
    logic [31:0] apb_rdata;

    modport master (
        output apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        input  apb_ready, apb_rdata
    );

    modport slave (
        input  apb_sel, apb_en, apb_write, apb_addr, apb_wdata,
        output apb_ready, apb_rdata
    );
endinterface

// File: rtl/i2c_apb_regs_apb_wait_timer.sv
// Access-phase wait-state counter; apb_ready rises once WAIT_STATES extra
// cycles have elapsed and the counter restarts for the next access.
module apb_wait_timer #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel_i,
    input  logic en_i,
    output logic ready_o
);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       access_s;
    logic       ready_s;

    assign access_s = sel_i & en_i;
    // Gated with rst_n so ready drops the instant reset is asserted.
    assign ready_s  = access_s & rst_n & (cnt_q == WS_L);
    assign ready_o  = ready_s;

    // Next count: advance while stalled, otherwise restart.
    always_comb begin
        cnt_d = 4'd0;
        if (access_s && !ready_s) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/i2c_apb_regs.sv
// APB register bank for the I2C master: configuration/command registers,
// status capture from the byte controller and interrupt generation.
module i2c_apb_regs
    import i2c_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          WAIT_STATES  = 0,
    parameter logic [15:0] PRESCALE_RST = PRESCALE_RST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_apb_regs_if.slave        apb,
    output logic                 core_en,
    output logic [15:0]          prescale,
    output logic [7:0]           txd,
    output logic                 cmd_sta,
    output logic                 cmd_sto,
    output logic                 cmd_rd,
    output logic                 cmd_wr,
    output logic                 cmd_ack_n,
    input  logic [7:0]           rxd,
    input  logic                 cmd_done,
    input  logic                 rx_ack,
    input  logic                 busy,
    input  logic                 arb_lost,
    output logic                 irq
);
    logic              ready_s, hit_s, wr_s, cmd_wr_s;
    logic [REG_AW-1:0] off_s;
    logic [31:0]       rdata_s;
    logic [4:0]        status_s;
    logic [15:0]       unused_wdata_s;

    logic [15:0] prescale_q, prescale_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [7:0]  txd_q, txd_d;
    logic [4:0]  cmd_q, cmd_d;    // {ack_n, wr, rd, sto, sta}
    logic [7:0]  rxd_q, rxd_d;
    logic        rx_ack_q, rx_ack_d;
    logic        al_q, al_d;
    logic        irq_flag_q, irq_flag_d;

    apb_wait_timer #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_i   (apb.apb_sel),
        .en_i    (apb.apb_en),
        .ready_o (ready_s)
    );

    assign off_s          = apb.apb_addr[REG_AW-1:0];
    assign hit_s          = (apb.apb_addr[31:REG_AW] == BASE_ADDR[31:REG_AW]);
    assign wr_s           = apb.apb_sel & apb.apb_en & apb.apb_write & ready_s & hit_s;
    assign cmd_wr_s       = wr_s & (off_s == OFF_CMD);
    assign unused_wdata_s = apb.apb_wdata[31:16];

    assign status_s = {irq_flag_q, al_q, rx_ack_q, cmd_q[CMD_RD] | cmd_q[CMD_WR], busy};

    // Register next-state: bus writes, command lifecycle and status capture.
    always_comb begin
        prescale_d = prescale_q;
        ctrl_d     = ctrl_q;
        txd_d      = txd_q;
        if (wr_s && off_s == OFF_PRESCALE) begin
            prescale_d = apb.apb_wdata[15:0];
        end else begin
            prescale_d = prescale_q;
        end
        if (wr_s && off_s == OFF_CTRL) begin
            ctrl_d = apb.apb_wdata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_s && off_s == OFF_TXDATA) begin
            txd_d = apb.apb_wdata[7:0];
        end else begin
            txd_d = txd_q;
        end
        // A command write landing with cmd_done/arb_lost overrides the clear.
        if (cmd_wr_s && ctrl_q[CTRL_EN]) begin
            cmd_d = apb.apb_wdata[4:0];
        end else if (cmd_done || arb_lost) begin
            cmd_d = {cmd_q[CMD_ACKN], 4'b0000};
        end else begin
            cmd_d = cmd_q;
        end
        if (cmd_done) begin
            rxd_d    = rxd;
            rx_ack_d = rx_ack;
        end else begin
            rxd_d    = rxd_q;
            rx_ack_d = rx_ack_q;
        end
        if (arb_lost) begin
            al_d = 1'b1;
        end else if (cmd_wr_s && apb.apb_wdata[CMD_STA]) begin
            al_d = 1'b0;
        end else begin
            al_d = al_q;
        end
        if (cmd_done || arb_lost) begin
            irq_flag_d = 1'b1;
        end else if (cmd_wr_s && apb.apb_wdata[CMD_IACK]) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_q;
        end
    end

    // Register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= PRESCALE_RST;
            ctrl_q     <= 2'b00;
            txd_q      <= 8'h00;
            cmd_q      <= 5'b00000;
            rxd_q      <= 8'h00;
            rx_ack_q   <= 1'b0;
            al_q       <= 1'b0;
            irq_flag_q <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            ctrl_q     <= ctrl_d;
            txd_q      <= txd_d;
            cmd_q      <= cmd_d;
            rxd_q      <= rxd_d;
            rx_ack_q   <= rx_ack_d;
            al_q       <= al_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Read mux; misses and idle cycles return zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ready_s && hit_s) begin
            case (off_s)
                OFF_PRESCALE: rdata_s = {16'h0000, prescale_q};
                OFF_CTRL:     rdata_s = {30'h0000_0000, ctrl_q};
                OFF_TXDATA:   rdata_s = {24'h00_0000, txd_q};
                OFF_CMD:      rdata_s = {27'h000_0000, cmd_q};
                OFF_RXDATA:   rdata_s = {24'h00_0000, rxd_q};
                OFF_STATUS:   rdata_s = {27'h000_0000, status_s};
                default:      rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign apb.apb_ready = ready_s;
    assign apb.apb_rdata = rdata_s;

    assign core_en   = ctrl_q[CTRL_EN];
    assign prescale  = prescale_q;
    assign txd       = txd_q;
    assign cmd_sta   = cmd_q[CMD_STA];
    assign cmd_sto   = cmd_q[CMD_STO];
    assign cmd_rd    = cmd_q[CMD_RD];
    assign cmd_wr    = cmd_q[CMD_WR];
    assign cmd_ack_n = cmd_q[CMD_ACKN];
    assign irq       = irq_flag_q & ctrl_q[CTRL_IEN];
endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed bench for i2c_apb_regs: three instances with 0, 2 and 3 wait states
// share one APB driver; the active instance is chosen by dut_sel.
module tb_i2c_apb_regs;
    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        sel, en, wr;
    logic [31:0] addr, wdata;
    int          dut_sel;
    logic [7:0]  rxd;
    logic        cmd_done, rx_ack, busy, arb_lost;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        core_en_w  [3];
    logic [15:0] prescale_w [3];
    logic [7:0]  txd_w      [3];
    logic        sta_w [3], sto_w [3], rd_w [3], wrc_w [3], ackn_w [3], irq_w [3];
    logic        act_ready;
    logic [31:0] act_rdata;

    always #5 clk = ~clk;

    i2c_apb_regs_if if0 ();
    i2c_apb_regs_if if1 ();
    i2c_apb_regs_if if2 ();

    assign if0.apb_sel = sel & (dut_sel == 0);
    assign if1.apb_sel = sel & (dut_sel == 1);
    assign if2.apb_sel = sel & (dut_sel == 2);
    assign if0.apb_en = en;     assign if1.apb_en = en;     assign if2.apb_en = en;
    assign if0.apb_write = wr;  assign if1.apb_write = wr;  assign if2.apb_write = wr;
    assign if0.apb_addr = addr; assign if1.apb_addr = addr; assign if2.apb_addr = addr;
    assign if0.apb_wdata = wdata; assign if1.apb_wdata = wdata; assign if2.apb_wdata = wdata;

    always_comb begin
        case (dut_sel)
            0:       begin act_ready = if0.apb_ready; act_rdata = if0.apb_rdata; end
            1:       begin act_ready = if1.apb_ready; act_rdata = if1.apb_rdata; end
            default: begin act_ready = if2.apb_ready; act_rdata = if2.apb_rdata; end
        endcase
    end

    i2c_apb_regs #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .apb(if0), .core_en(core_en_w[0]), .prescale(prescale_w[0]),
        .txd(txd_w[0]), .cmd_sta(sta_w[0]), .cmd_sto(sto_w[0]), .cmd_rd(rd_w[0]), .cmd_wr(wrc_w[0]),
        .cmd_ack_n(ackn_w[0]), .rxd(rxd), .cmd_done(cmd_done), .rx_ack(rx_ack), .busy(busy),
        .arb_lost(arb_lost), .irq(irq_w[0]));
    i2c_apb_regs #(.WAIT_STATES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .apb(if1), .core_en(core_en_w[1]), .prescale(prescale_w[1]),
        .txd(txd_w[1]), .cmd_sta(sta_w[1]), .cmd_sto(sto_w[1]), .cmd_rd(rd_w[1]), .cmd_wr(wrc_w[1]),
        .cmd_ack_n(ackn_w[1]), .rxd(rxd), .cmd_done(cmd_done), .rx_ack(rx_ack), .busy(busy),
        .arb_lost(arb_lost), .irq(irq_w[1]));
    i2c_apb_regs #(.WAIT_STATES(3)) dut2 (
        .clk(clk), .rst_n(rst_n & rst2_n), .apb(if2), .core_en(core_en_w[2]), .prescale(prescale_w[2]),
        .txd(txd_w[2]), .cmd_sta(sta_w[2]), .cmd_sto(sto_w[2]), .cmd_rd(rd_w[2]), .cmd_wr(wrc_w[2]),
        .cmd_ack_n(ackn_w[2]), .rxd(rxd), .cmd_done(cmd_done), .rx_ack(rx_ack), .busy(busy),
        .arb_lost(arb_lost), .irq(irq_w[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic pulse_done, output logic [31:0] rdat, output int cyc);
        bit done;
        done = 1'b0;
        rdat = 32'h0;
        @(negedge clk);
        dut_sel = idx; sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b1;
        cyc = 1;
        while (!done) begin
            #1;
            if (act_ready) begin
                rdat = act_rdata;
                if (pulse_done) cmd_done = 1'b1;
                done = 1'b1;
            end else if (cyc >= 20) begin
                check_val("ready_timeout", 32'h0, 32'h1);
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        sel = 1'b0; en = 1'b0; cmd_done = 1'b0;
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int c;
        apb_xfer(idx, 1'b1, a, d, 1'b0, r, c);
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int c;
        apb_xfer(idx, 1'b0, a, 32'h0, 1'b0, r, c);
        check_val(tag, r, exp);
    endtask

    task automatic pulse(input bit is_al);
        @(negedge clk);
        if (is_al) arb_lost = 1'b1; else cmd_done = 1'b1;
        @(negedge clk);
        arb_lost = 1'b0; cmd_done = 1'b0;
    endtask

    logic [31:0] rv;
    int          cy;
    logic [31:0] exp_rst [6] = '{32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        rst_n = 1'b0; rst2_n = 1'b1; sel = 1'b0; en = 1'b0; wr = 1'b0;
        addr = 32'h0; wdata = 32'h0; dut_sel = 0;
        rxd = 8'h00; cmd_done = 1'b0; rx_ack = 1'b0; busy = 1'b0; arb_lost = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_prescale", {16'h0, prescale_w[0]}, 32'h0000_FFFF);
        check_val("rst_outs", {27'h0, core_en_w[0], irq_w[0], sta_w[0], wrc_w[0], ackn_w[0]}, 32'h0);
        rst_n = 1'b1;

        // Reset readback on the zero-wait instance, ready in the first cycle.
        for (int i = 0; i < 6; i++) begin
            apb_xfer(0, 1'b0, 32'(i * 4), 32'h0, 1'b0, rv, cy);
            check_val($sformatf("rst_rd_%0d", i * 4), rv, exp_rst[i]);
            check_val($sformatf("rst_cyc_%0d", i * 4), 32'(cy), 32'd1);
        end

        // Two wait states.
        apb_xfer(1, 1'b1, 32'h00, 32'h0063, 1'b0, rv, cy);
        check_val("ws2_wr_cyc", 32'(cy), 32'd3);
        check_val("ws2_prescale", {16'h0, prescale_w[1]}, 32'h0063);
        apb_xfer(1, 1'b0, 32'h00, 32'h0, 1'b0, rv, cy);
        check_val("ws2_rd_cyc", 32'(cy), 32'd3);
        check_val("ws2_rd", rv, 32'h0063);

        // Command issue and completion.
        wr_reg(0, 32'h04, 32'h3);
        check_val("core_en", {31'h0, core_en_w[0]}, 32'h1);
        wr_reg(0, 32'h08, 32'hA5);
        check_val("txd", {24'h0, txd_w[0]}, 32'hA5);
        rd_chk("txdata_rd", 0, 32'h08, 32'hA5);
        wr_reg(0, 32'h0C, 32'h09);
        check_val("cmd_bits", {28'h0, wrc_w[0], rd_w[0], sto_w[0], sta_w[0]}, 32'h9);
        rd_chk("status_tip", 0, 32'h14, 32'h02);
        rd_chk("cmd_rd", 0, 32'h0C, 32'h09);
        rxd = 8'h11;
        pulse(1'b0);
        check_val("cmd_clr", {28'h0, wrc_w[0], rd_w[0], sto_w[0], sta_w[0]}, 32'h0);
        check_val("irq_set", {31'h0, irq_w[0]}, 32'h1);
        rd_chk("status_irq", 0, 32'h14, 32'h10);
        rd_chk("rxdata_11", 0, 32'h10, 32'h11);

        // cmd_done coincident with IACK: set wins; capture still happens.
        rxd = 8'h3C; rx_ack = 1'b1;
        apb_xfer(0, 1'b1, 32'h0C, 32'h80, 1'b1, rv, cy);
        rd_chk("rxdata_3c", 0, 32'h10, 32'h3C);
        rd_chk("status_setwins", 0, 32'h14, 32'h14);
        check_val("irq_setwins", {31'h0, irq_w[0]}, 32'h1);
        wr_reg(0, 32'h0C, 32'h80);
        check_val("irq_iack", {31'h0, irq_w[0]}, 32'h0);
        rd_chk("status_iack", 0, 32'h14, 32'h04);

        // Command write coincident with cmd_done: new bits load.
        apb_xfer(0, 1'b1, 32'h0C, 32'h09, 1'b1, rv, cy);
        check_val("cmd_writewins", {28'h0, wrc_w[0], rd_w[0], sto_w[0], sta_w[0]}, 32'h9);
        rd_chk("status_ww", 0, 32'h14, 32'h16);
        pulse(1'b1);
        check_val("cmd_al_clr", {28'h0, wrc_w[0], rd_w[0], sto_w[0], sta_w[0]}, 32'h0);
        rd_chk("status_al", 0, 32'h14, 32'h1C);
        wr_reg(0, 32'h0C, 32'h81);
        rd_chk("status_al_clr", 0, 32'h14, 32'h04);
        rd_chk("cmd_sta_only", 0, 32'h0C, 32'h01);

        // Core disabled, misses.
        wr_reg(0, 32'h04, 32'h0);
        wr_reg(0, 32'h0C, 32'h04);
        check_val("cmd_rd_dis", {31'h0, rd_w[0]}, 32'h0);
        check_val("cmd_dis_bits", {28'h0, wrc_w[0], rd_w[0], sto_w[0], sta_w[0]}, 32'h1);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rv, cy);
        check_val("miss_rd", rv, 32'h0);
        check_val("miss_cyc", 32'(cy), 32'd1);
        wr_reg(0, 32'h40, 32'hFFFF_FFFF);
        apb_xfer(0, 1'b1, 32'h0000_0100, 32'h1234, 1'b0, rv, cy);
        check_val("base_miss_cyc", 32'(cy), 32'd1);
        check_val("base_miss_ps", {16'h0, prescale_w[0]}, 32'h0000_FFFF);
        rd_chk("base_miss_rd", 0, 32'h0000_0100, 32'h0);
        rd_chk("ps_unchanged", 0, 32'h00, 32'h0000_FFFF);
        rd_chk("ctrl_zero", 0, 32'h04, 32'h0);
        busy = 1'b1;
        rd_chk("status_busy", 0, 32'h14, 32'h05);
        busy = 1'b0;

        // Reset asserted while the 3-wait-state instance shows ready on a write.
        @(negedge clk);
        dut_sel = 2; sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 32'h00; wdata = 32'h1234;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("ws3_ready", {31'h0, act_ready}, 32'h1);
        rst2_n = 1'b0;
        #1;
        check_val("rst_ready_drop", {31'h0, act_ready}, 32'h0);
        @(negedge clk);
        sel = 1'b0; en = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        check_val("rst_ps_out", {16'h0, prescale_w[2]}, 32'h0000_FFFF);
        apb_xfer(2, 1'b0, 32'h00, 32'h0, 1'b0, rv, cy);
        check_val("rst_ps_rd", rv, 32'h0000_FFFF);
        check_val("ws3_cyc", 32'(cy), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
